pool_window_gen_2x2: RTL and testbench
======================================

POOL_WINDOW_GEN_2X2 -- requirements
Module: pool_window_gen_2x2

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: signed pixel width in bits.
REQ-002 The block SHALL have parameter IMG_W, default 24: feature-map width in pixels, minimum 2.
REQ-003 The block SHALL have parameter IMG_H, default 24: feature-map height in pixels, minimum 2.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port din, input, signed WIDTH bits: pixel stream in raster order (row-major, column 0 first).
REQ-007 The block SHALL have port din_valid, input, 1 bit: din is consumed on any rising edge where din_valid is 1.
REQ-008 The block SHALL have ports a, b, c, d, each an output, signed WIDTH bits: the 2x2 window, with a = top-left, b = top-right, c = bottom-left, d = bottom-right.
REQ-009 The block SHALL have port win_valid, output, 1 bit: a, b, c and d hold a complete window.

Function
REQ-010 The block SHALL keep col_cnt (0..IMG_W-1) and row_cnt (0..IMG_H-1), both advancing only on accepted pixels.
- col_cnt wraps to 0 after IMG_W-1 and increments row_cnt.
- row_cnt wraps to 0 after IMG_H-1, which starts a new frame with no idle cycle.
REQ-011 The block SHALL store each accepted pixel of an even row (row_cnt[0]=0) in a one-row line buffer of IMG_W entries, indexed by col_cnt.
REQ-012 The block SHALL hold the previously accepted pixel of the current row in a one-entry register.
REQ-013 The block SHALL emit a window on acceptance of a pixel with row_cnt odd and col_cnt odd:
- a = linebuf[col_cnt-1]
- b = linebuf[col_cnt]
- c = the held previous pixel
- d = din
REQ-014 a, b, c, d and win_valid SHALL be registered, with win_valid asserted exactly one cycle after the accepting edge (latency 1).
REQ-015 win_valid SHALL be a single-cycle pulse per window, deasserted in every cycle with no emitting acceptance, including back-to-back valid cycles.
REQ-016 a, b, c and d SHALL hold their last values while win_valid is 0.
REQ-017 Gaps in din_valid SHALL NOT change the counters, the buffers or the window contents.
REQ-018 With odd IMG_W the last column SHALL be consumed but never appear in a window; with odd IMG_H the last row SHALL be consumed and never produce a window (floor pooling).
REQ-019 A full frame SHALL produce exactly floor(IMG_W/2)*floor(IMG_H/2) windows.
REQ-020 The block SHALL perform no arithmetic on pixel data: values pass bit-exact and sign is preserved.
REQ-021 The block SHALL apply no backpressure; the downstream consumer SHALL accept every win_valid pulse.

Reset
REQ-022 While rst=1 the block SHALL force col_cnt=0, row_cnt=0, win_valid=0 and a=b=c=d=0, asynchronously.
REQ-023 Reset asserted mid-frame SHALL abort the frame; the first pixel accepted after deassertion is pixel (0,0) of a new frame.
REQ-024 Line-buffer and previous-pixel contents SHALL NOT be reset; they are overwritten before use.

Configuration
REQ-025 With macro POOL_WIN_FRAME_DONE_EN defined, the block SHALL add output frame_done (1 bit, reset 0):
- registered, one-cycle pulse
- asserted one cycle after acceptance of pixel (IMG_H-1, IMG_W-1)
- coincides with the last win_valid when IMG_W and IMG_H are both even
REQ-026 Without POOL_WIN_FRAME_DONE_EN, the frame_done port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-027 Scenario: IMG_W=4, IMG_H=4, pixels 1..16 sent continuously -> windows (1,2,5,6), (3,4,7,8), (9,10,13,14), (11,12,15,16), each one cycle after pixels 6, 8, 14 and 16.
REQ-028 Scenario: same frame with din_valid toggling 1/0 -> same four windows, each one cycle after its d pixel; win_valid is a one-cycle pulse and data holds between pulses.
REQ-029 Scenario: WIDTH=8, pixels -128, 127, -1, 0 in a 2x2 frame -> a=-128, b=127, c=-1, d=0, sign preserved.
REQ-030 Scenario: IMG_W=5, IMG_H=3, pixels 1..15 -> only windows (1,2,6,7) and (3,4,8,9); columns 5, 10 and 15 and row 3 are dropped.
REQ-031 Scenario: rst pulsed after pixel 7 of a 4x4 frame, then 1..16 sent -> outputs 0 during reset; the four windows of REQ-027 follow with no stale data.
REQ-032 Scenario: with POOL_WIN_FRAME_DONE_EN, two back-to-back 4x4 frames -> exactly two frame_done pulses, each coincident with window (11,12,15,16).

Source files
------------

// File: rtl/pool_window_gen_2x2.sv
// pool_window_gen_2x2: builds non-overlapping 2x2 pooling windows from a raster pixel stream
// Ports: clk, rst (async, active high), din/din_valid (pixel stream in),
//        a/b/c/d (window: top-left, top-right, bottom-left, bottom-right), win_valid (window pulse)
// Optional macro POOL_WIN_FRAME_DONE_EN adds frame_done, a one-cycle pulse after the last pixel of a frame.
module pool_window_gen_2x2 #(
  parameter int WIDTH = 8,
  parameter int IMG_W = 24,
  parameter int IMG_H = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] din,
  input  logic                    din_valid,
  output logic signed [WIDTH-1:0] a,
  output logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] c,
  output logic signed [WIDTH-1:0] d,
`ifdef POOL_WIN_FRAME_DONE_EN
  output logic                    frame_done,
`endif
  output logic                    win_valid
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic signed [WIDTH-1:0] lb_q [IMG_W];
  logic signed [WIDTH-1:0] prev_q;
  logic signed [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic win_q, win_d, col_last, row_last, emit;
  always_comb begin
    col_last = col_q == CW'(IMG_W - 1);
    row_last = row_q == RW'(IMG_H - 1);
    // a window closes on the bottom-right pixel: odd row, odd column
    emit     = din_valid && row_q[0] && col_q[0];
    col_d    = !din_valid ? col_q : col_last ? '0 : col_q + CW'(1);
    row_d    = !(din_valid && col_last) ? row_q : row_last ? '0 : row_q + RW'(1);
    a_d      = emit ? lb_q[col_q - CW'(1)] : a_q;
    b_d      = emit ? lb_q[col_q] : b_q;
    c_d      = emit ? prev_q : c_q;
    d_d      = emit ? din : d_q;
    win_d    = emit;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      d_q   <= '0;
      win_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      a_q   <= a_d;
      b_q   <= b_d;
      c_q   <= c_d;
      d_q   <= d_d;
      win_q <= win_d;
    end
  end
  // storage is never reset: every entry is rewritten before a window reads it
  always_ff @(posedge clk) begin
    if (din_valid && !row_q[0]) lb_q[col_q] <= din;
    if (din_valid) prev_q <= din;
  end
  assign a         = a_q;
  assign b         = b_q;
  assign c         = c_q;
  assign d         = d_q;
  assign win_valid = win_q;
`ifdef POOL_WIN_FRAME_DONE_EN
  logic fd_q, fd_d;
  assign fd_d = din_valid && col_last && row_last;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fd_q <= 1'b0;
    else     fd_q <= fd_d;
  end
  assign frame_done = fd_q;
`endif
endmodule

// File: tb/tb_pool_window_gen_2x2.sv
// tb_pool_window_gen_2x2: scenario tasks against a frame-array reference model on four geometries
module tb_pool_window_gen_2x2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic signed [7:0] din = '0;
  logic [3:0] vld = '0;
  logic signed [7:0] oa [4];
  logic signed [7:0] ob [4];
  logic signed [7:0] oc [4];
  logic signed [7:0] od [4];
  logic [3:0] ow;
  logic [3:0] ofd;
  int n_chk = 0;
  int n_fail = 0;
  int geo_w [4] = '{4, 5, 2, 24};
  int geo_h [4] = '{4, 3, 2, 24};
  int pos [4] = '{0, 0, 0, 0};
  int dut_win [4] = '{0, 0, 0, 0};
  int fd_cnt [4] = '{0, 0, 0, 0};
  logic signed [7:0] img [4][24][24];
  logic signed [7:0] ea [4];
  logic signed [7:0] eb [4];
  logic signed [7:0] ec [4];
  logic signed [7:0] ed [4];

  always #5 clk = ~clk;

`ifdef POOL_WIN_FRAME_DONE_EN
  pool_window_gen_2x2 #(.WIDTH(8), .IMG_W(4), .IMG_H(4)) u0 (.clk(clk), .rst(rst), .din(din), .din_valid(vld[0]),
    .a(oa[0]), .b(ob[0]), .c(oc[0]), .d(od[0]), .frame_done(ofd[0]), .win_valid(ow[0]));
  pool_window_gen_2x2 #(.WIDTH(8), .IMG_W(5), .IMG_H(3)) u1 (.clk(clk), .rst(rst), .din(din), .din_valid(vld[1]),
    .a(oa[1]), .b(ob[1]), .c(oc[1]), .d(od[1]), .frame_done(ofd[1]), .win_valid(ow[1]));
  pool_window_gen_2x2 #(.WIDTH(8), .IMG_W(2), .IMG_H(2)) u2 (.clk(clk), .rst(rst), .din(din), .din_valid(vld[2]),
    .a(oa[2]), .b(ob[2]), .c(oc[2]), .d(od[2]), .frame_done(ofd[2]), .win_valid(ow[2]));
  pool_window_gen_2x2 #(.WIDTH(8)) u3 (.clk(clk), .rst(rst), .din(din), .din_valid(vld[3]),
    .a(oa[3]), .b(ob[3]), .c(oc[3]), .d(od[3]), .frame_done(ofd[3]), .win_valid(ow[3]));
`else
  assign ofd = '0;
  pool_window_gen_2x2 #(.WIDTH(8), .IMG_W(4), .IMG_H(4)) u0 (.clk(clk), .rst(rst), .din(din), .din_valid(vld[0]),
    .a(oa[0]), .b(ob[0]), .c(oc[0]), .d(od[0]), .win_valid(ow[0]));
  pool_window_gen_2x2 #(.WIDTH(8), .IMG_W(5), .IMG_H(3)) u1 (.clk(clk), .rst(rst), .din(din), .din_valid(vld[1]),
    .a(oa[1]), .b(ob[1]), .c(oc[1]), .d(od[1]), .win_valid(ow[1]));
  pool_window_gen_2x2 #(.WIDTH(8), .IMG_W(2), .IMG_H(2)) u2 (.clk(clk), .rst(rst), .din(din), .din_valid(vld[2]),
    .a(oa[2]), .b(ob[2]), .c(oc[2]), .d(od[2]), .win_valid(ow[2]));
  pool_window_gen_2x2 #(.WIDTH(8)) u3 (.clk(clk), .rst(rst), .din(din), .din_valid(vld[3]),
    .a(oa[3]), .b(ob[3]), .c(oc[3]), .d(od[3]), .win_valid(ow[3]));
`endif

  // one clock on instance i; the model places the pixel in its frame image and,
  // if it completes a 2x2 block, expects that block one cycle later
  task automatic step(input int i, input logic v, input logic signed [7:0] x);
    int r, col;
    logic ev, fd_e;
    din = x;
    vld = '0;
    vld[i] = v;
    @(posedge clk);
    #1;
    vld = '0;
    ev = 1'b0;
    fd_e = 1'b0;
    if (v) begin
      r = pos[i] / geo_w[i];
      col = pos[i] % geo_w[i];
      img[i][r][col] = x;
      if (r % 2 == 1 && col % 2 == 1) begin
        ev = 1'b1;
        ea[i] = img[i][r-1][col-1];
        eb[i] = img[i][r-1][col];
        ec[i] = img[i][r][col-1];
        ed[i] = img[i][r][col];
      end
      fd_e = pos[i] == geo_w[i] * geo_h[i] - 1;
      pos[i] = (pos[i] + 1) % (geo_w[i] * geo_h[i]);
    end
    n_chk += 5;
    if (ow[i] !== ev) begin n_fail++; $display("FAIL win_valid inst%0d pos%0d got %b exp %b", i, pos[i], ow[i], ev); end
    if (oa[i] !== ea[i]) begin n_fail++; $display("FAIL a inst%0d pos%0d got %0d exp %0d", i, pos[i], oa[i], ea[i]); end
    if (ob[i] !== eb[i]) begin n_fail++; $display("FAIL b inst%0d pos%0d got %0d exp %0d", i, pos[i], ob[i], eb[i]); end
    if (oc[i] !== ec[i]) begin n_fail++; $display("FAIL c inst%0d pos%0d got %0d exp %0d", i, pos[i], oc[i], ec[i]); end
    if (od[i] !== ed[i]) begin n_fail++; $display("FAIL d inst%0d pos%0d got %0d exp %0d", i, pos[i], od[i], ed[i]); end
`ifdef POOL_WIN_FRAME_DONE_EN
    n_chk++;
    if (ofd[i] !== fd_e) begin n_fail++; $display("FAIL frame_done inst%0d got %b exp %b", i, ofd[i], fd_e); end
`endif
    if (ow[i] === 1'b1) dut_win[i]++;
    if (ofd[i] === 1'b1) fd_cnt[i]++;
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (ow[i] !== 1'b0 || oa[i] !== 8'sd0 || ob[i] !== 8'sd0 || oc[i] !== 8'sd0 || od[i] !== 8'sd0 || ofd[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL %s inst%0d got v=%b a=%0d b=%0d c=%0d d=%0d fd=%b exp all 0", tag, i, ow[i], oa[i], ob[i], oc[i], od[i], ofd[i]);
      end
      pos[i] = 0;
      ea[i] = '0; eb[i] = '0; ec[i] = '0; ed[i] = '0;
    end
  endtask

  task automatic check_count(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin n_fail++; $display("FAIL %s got %0d exp %0d", tag, got, exp); end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1 check_zero("reset_async");
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1 check_zero("reset_release");
  endtask

  task automatic test_seq_4x4();
    int w0 = dut_win[0];
    for (int k = 1; k <= 16; k++) step(0, 1'b1, 8'(k));
    step(0, 1'b0, 8'sd0);
    check_count("seq_4x4_windows", dut_win[0] - w0, 4);
  endtask

  task automatic test_gaps_4x4();
    int w0 = dut_win[0];
    for (int k = 1; k <= 16; k++) begin
      step(0, 1'b1, 8'(k));
      step(0, 1'b0, 8'(100 + k));
    end
    check_count("gaps_4x4_windows", dut_win[0] - w0, 4);
  endtask

  task automatic test_sign_2x2();
    logic signed [7:0] px [4] = '{-8'sd128, 8'sd127, -8'sd1, 8'sd0};
    for (int k = 0; k < 4; k++) step(2, 1'b1, px[k]);
    n_chk++;
    if (oa[2] !== -8'sd128 || ob[2] !== 8'sd127 || oc[2] !== -8'sd1 || od[2] !== 8'sd0) begin
      n_fail++;
      $display("FAIL sign_2x2 got %0d %0d %0d %0d exp -128 127 -1 0", oa[2], ob[2], oc[2], od[2]);
    end
  endtask

  task automatic test_odd_5x3();
    int w0 = dut_win[1];
    for (int k = 1; k <= 15; k++) step(1, 1'b1, 8'(k));
    step(1, 1'b0, 8'sd0);
    check_count("odd_5x3_windows", dut_win[1] - w0, 2);
  endtask

  task automatic test_reset_mid();
    int w0;
    for (int k = 1; k <= 7; k++) step(0, 1'b1, 8'(50 + k));
    #2 rst = 1'b1;
    #1 check_zero("reset_mid");
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1 check_zero("reset_mid_release");
    w0 = dut_win[0];
    for (int k = 1; k <= 16; k++) step(0, 1'b1, 8'(k));
    check_count("reset_mid_windows", dut_win[0] - w0, 4);
  endtask

  task automatic test_back_to_back();
    int w0 = dut_win[0];
    int f0 = fd_cnt[0];
    for (int k = 0; k < 32; k++) step(0, 1'b1, 8'($urandom));
    step(0, 1'b0, 8'sd0);
    check_count("b2b_windows", dut_win[0] - w0, 8);
`ifdef POOL_WIN_FRAME_DONE_EN
    check_count("b2b_frame_done", fd_cnt[0] - f0, 2);
`else
    check_count("b2b_no_frame_done", fd_cnt[0] - f0, 0);
`endif
  endtask

  task automatic test_random_24();
    int w0 = dut_win[3];
    int acc = 0;
    while (acc < 24 * 24) begin
      logic v = 1'($urandom_range(0, 3) != 0);
      step(3, v, 8'($urandom));
      if (v) acc++;
    end
    step(3, 1'b0, 8'sd0);
    check_count("random_24_windows", dut_win[3] - w0, 144);
  endtask

  initial begin
    test_reset();
    test_seq_4x4();
    test_gaps_4x4();
    test_sign_2x2();
    test_odd_5x3();
    test_reset_mid();
    test_back_to_back();
    test_random_24();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
